// File: rtl/instr_pkg.sv
// Shared definitions for the instruction decode path: default field widths,
// type encodings, the default legality mask and the decoded-instruction record.
package instr_pkg;

  localparam int INSTR_W_DEF = 32;
  localparam int TYPE_W_DEF  = 3;
  localparam int FUNC_W_DEF  = 5;
  localparam int REG_W_DEF   = 8;
  localparam int IMM_W_DEF   = INSTR_W_DEF - TYPE_W_DEF - FUNC_W_DEF;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [TYPE_W_DEF-1:0] {
    TYPE_STACK = 3'd1,
    TYPE_ALU1  = 3'd2,
    TYPE_ALU2  = 3'd3,
    TYPE_DMA   = 3'd4,
    TYPE_UART  = 3'd6,
    TYPE_JMP   = 3'd7
  } instr_type_e;

  localparam logic [7:0] VALID_TYPE_MASK_DEF = 8'b11011110;

  typedef struct packed {
    logic [TYPE_W_DEF-1:0] itype;
    logic [FUNC_W_DEF-1:0] func;
    logic [REG_W_DEF-1:0]  t;
    logic [REG_W_DEF-1:0]  s;
    logic [REG_W_DEF-1:0]  f;
    logic [IMM_W_DEF-1:0]  imm;
    logic                  illegal;
  } decoded_instr_t;

endpackage

// File: rtl/instr_field_split.sv
// Combinational field extraction and legality check for one instruction word.
// Register codes of an illegal instruction are zeroed so nothing downstream can act on them.
module instr_field_split
  import instr_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int TYPE_W  = TYPE_W_DEF,
  parameter int FUNC_W  = FUNC_W_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter logic [2**TYPE_W-1:0] VALID_TYPE_MASK = VALID_TYPE_MASK_DEF
) (
  input  logic [INSTR_W-1:0]               instr,
  output logic [TYPE_W-1:0]                itype,
  output logic [FUNC_W-1:0]                func,
  output logic [REG_W-1:0]                 t_reg,
  output logic [REG_W-1:0]                 s_reg,
  output logic [REG_W-1:0]                 f_reg,
  output logic [INSTR_W-TYPE_W-FUNC_W-1:0] imm,
  output logic                             illegal
);

  localparam int IMM_W = INSTR_W - TYPE_W - FUNC_W;

  assign itype   = instr[INSTR_W-1 -: TYPE_W];
  assign func    = instr[INSTR_W-TYPE_W-1 -: FUNC_W];
  assign imm     = instr[IMM_W-1:0];
  assign illegal = ~VALID_TYPE_MASK[itype];
  assign t_reg   = illegal ? '0 : instr[3*REG_W-1 -: REG_W];
  assign s_reg   = illegal ? '0 : instr[2*REG_W-1 -: REG_W];
  assign f_reg   = illegal ? '0 : instr[REG_W-1:0];

endmodule

// File: rtl/instr_decode_stage.sv
// Pipelined decode stage: valid/ready in, registered decoded result out,
// backed by one skid entry so in_ready never depends combinationally on out_ready.
module instr_decode_stage
  import instr_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int TYPE_W  = TYPE_W_DEF,
  parameter int FUNC_W  = FUNC_W_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter logic [2**TYPE_W-1:0] VALID_TYPE_MASK = VALID_TYPE_MASK_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [INSTR_W-1:0]               in_instr,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [TYPE_W-1:0]                out_type,
  output logic [FUNC_W-1:0]                out_func,
  output logic [REG_W-1:0]                 out_t_reg,
  output logic [REG_W-1:0]                 out_s_reg,
  output logic [REG_W-1:0]                 out_f_reg,
  output logic [INSTR_W-TYPE_W-FUNC_W-1:0] out_imm,
  output logic                             out_illegal,
  output logic [CNT_W-1:0]                 illegal_count
);

  localparam int IMM_W   = INSTR_W - TYPE_W - FUNC_W;
  localparam int ENTRY_W = 1 + TYPE_W + FUNC_W + 3*REG_W + IMM_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  if (INSTR_W != TYPE_W + FUNC_W + 3*REG_W) begin : g_width_check
    $error("instr_decode_stage: INSTR_W must equal TYPE_W+FUNC_W+3*REG_W");
  end

  logic [TYPE_W-1:0] dec_type;
  logic [FUNC_W-1:0] dec_func;
  logic [REG_W-1:0]  dec_t, dec_s, dec_f;
  logic [IMM_W-1:0]  dec_imm;
  logic              dec_illegal;
  logic [ENTRY_W-1:0] dec_entry, out_q, skid_q;
  logic              skid_valid;
  logic              accept, deliver;

  instr_field_split #(
    .INSTR_W(INSTR_W), .TYPE_W(TYPE_W), .FUNC_W(FUNC_W), .REG_W(REG_W),
    .VALID_TYPE_MASK(VALID_TYPE_MASK)
  ) u_split (
    .instr(in_instr), .itype(dec_type), .func(dec_func), .t_reg(dec_t),
    .s_reg(dec_s), .f_reg(dec_f), .imm(dec_imm), .illegal(dec_illegal)
  );

  assign dec_entry = {dec_illegal, dec_type, dec_func, dec_t, dec_s, dec_f, dec_imm};
  assign {out_illegal, out_type, out_func, out_t_reg, out_s_reg, out_f_reg, out_imm} = out_q;

  // Handshake: a word moves when valid && ready on the same rising edge.
  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      skid_valid    <= 1'b0;
      in_ready      <= 1'b1;
      out_q         <= '0;
      skid_q        <= '0;
      illegal_count <= '0;
    end else begin
      // A delivery in a flush cycle was seen downstream, so it still counts.
      if (deliver && out_illegal && illegal_count != CNT_MAX)
        illegal_count <= illegal_count + CNT_ONE;
      if (flush) begin
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end else if (!out_valid || out_ready) begin
        if (skid_valid) begin
          out_q      <= skid_q;
          out_valid  <= 1'b1;
          skid_valid <= 1'b0;
          in_ready   <= 1'b1;
        end else if (accept) begin
          out_q     <= dec_entry;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_q     <= dec_entry;
        skid_valid <= 1'b1;
        in_ready   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: decode table, backpressure/flush/saturation
// sequences and a randomized run against a 2-deep FIFO reference model.
module tb_instr_decode_stage;
  import instr_pkg::*;

  localparam int DW = 57;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic        in_ready, out_valid, out_illegal;
  logic [2:0]  out_type;
  logic [4:0]  out_func;
  logic [7:0]  out_t_reg, out_s_reg, out_f_reg;
  logic [23:0] out_imm;
  logic [15:0] illegal_count;

  logic        flush_s, in_valid_s, out_ready_s;
  logic [31:0] in_instr_s;
  logic        in_ready_s, out_valid_s, out_illegal_s;
  logic [2:0]  out_type_s;
  logic [4:0]  out_func_s;
  logic [7:0]  out_t_reg_s, out_s_reg_s, out_f_reg_s;
  logic [23:0] out_imm_s;
  logic [1:0]  illegal_count_s;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int unsigned m_cnt;

  always #5 clk = ~clk;

  instr_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_type(out_type), .out_func(out_func), .out_t_reg(out_t_reg),
    .out_s_reg(out_s_reg), .out_f_reg(out_f_reg), .out_imm(out_imm),
    .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  instr_decode_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .in_instr(in_instr_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
    .out_type(out_type_s), .out_func(out_func_s), .out_t_reg(out_t_reg_s),
    .out_s_reg(out_s_reg_s), .out_f_reg(out_f_reg_s), .out_imm(out_imm_s),
    .out_illegal(out_illegal_s), .illegal_count(illegal_count_s)
  );

  wire [DW-1:0] act = {out_illegal, out_type, out_func, out_t_reg, out_s_reg, out_f_reg, out_imm};

  // Reference decode from the field rules, using plain arithmetic on the word.
  function automatic logic [DW-1:0] ref_decode(input logic [31:0] w);
    int unsigned ty, fn, t, s, f, imm;
    logic [7:0] mask;
    logic ill;
    mask = 8'b11011110;
    ty  = w / (1 << 29);
    fn  = (w / (1 << 24)) % 32;
    t   = (w / (1 << 16)) % 256;
    s   = (w / 256) % 256;
    f   = w % 256;
    imm = w % (1 << 24);
    ill = !mask[ty];
    if (ill) begin
      t = 0; s = 0; f = 0;
    end
    return {ill, ty[2:0], fn[4:0], t[7:0], s[7:0], f[7:0], imm[23:0]};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0]   instr;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl[7];

  logic [31:0]   words[3];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] prev_act;
  logic          held, acc, del;
  int            idx, exp_cnt;

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_instr = '0;
    flush_s = 1'b0; in_valid_s = 1'b0; out_ready_s = 1'b1; in_instr_s = '0;
    reset_dut();

    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_count", illegal_count, 0);
    chk("reset_fields", act, 0);

    // {illegal, type, func, t, s, f, imm}
    tbl[0] = '{32'h4A030201, {1'b0, 3'd2, 5'h0A, 8'h03, 8'h02, 8'h01, 24'h030201}};
    tbl[1] = '{32'hA1FFEEDD, {1'b1, 3'd5, 5'h01, 8'h00, 8'h00, 8'h00, 24'hFFEEDD}};
    tbl[2] = '{32'hE7123456, {1'b0, 3'd7, 5'h07, 8'h12, 8'h34, 8'h56, 24'h123456}};
    tbl[3] = '{32'h00AABBCC, {1'b1, 3'd0, 5'h00, 8'h00, 8'h00, 8'h00, 24'hAABBCC}};
    tbl[4] = '{32'h3FFFFFFF, {1'b0, 3'd1, 5'h1F, 8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF}};
    tbl[5] = '{32'hDF010203, {1'b0, 3'd6, 5'h1F, 8'h01, 8'h02, 8'h03, 24'h010203}};
    tbl[6] = '{32'h80000001, {1'b0, 3'd4, 5'h00, 8'h00, 8'h00, 8'h01, 24'h000001}};

    exp_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_instr = tbl[i].instr;
      tick();
      in_valid = 1'b0;
      chk($sformatf("tbl%0d_valid", i), out_valid, 1);
      chk($sformatf("tbl%0d_fields", i), act, tbl[i].exp);
      tick();
      if (tbl[i].exp[DW-1]) exp_cnt++;
      chk($sformatf("tbl%0d_count", i), illegal_count, exp_cnt);
      chk($sformatf("tbl%0d_drained", i), out_valid, 0);
    end

    // Saturation on the narrow-counter instance
    for (int i = 0; i < 5; i++) begin
      in_valid_s = 1'b1;
      in_instr_s = 32'hA0000000 + i;
      tick();
      in_valid_s = 1'b0;
      tick();
      chk($sformatf("sat%0d", i), illegal_count_s, (i + 1 > 3) ? 3 : i + 1);
    end

    // Backpressure: A,B fill the stage, C waits, then all drain in order
    reset_dut();
    words[0] = 32'h41000001; words[1] = 32'h61000002; words[2] = 32'hE1000003;
    got_q.delete();
    idx = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = words[0];
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc == 3) out_ready = 1'b1;
      if (cyc == 2) begin
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_hold_a", act, ref_decode(words[0]));
      end
      if (out_valid && out_ready) got_q.push_back(act);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) in_instr = words[idx];
        else in_valid = 1'b0;
      end
    end
    chk("bp_count", got_q.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < got_q.size()) chk($sformatf("bp_order%0d", i), got_q[i], ref_decode(words[i]));

    // Flush with both entries full, then with one entry and in_ready high
    reset_dut();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = words[0]; tick();
    in_instr = words[1]; tick();
    flush = 1'b1;
    in_instr = words[2]; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_full_valid", out_valid, 0);
    chk("flush_full_ready", in_ready, 1);
    in_valid = 1'b1;
    in_instr = words[0]; tick();
    flush = 1'b1;
    in_instr = 32'h7E0000DD; tick();
    flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    chk("flush_drop_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("flush_quiet%0d", i), out_valid, 0);
    end

    // Randomized run against the FIFO model
    reset_dut();
    exp_q.delete();
    m_cnt = 0;
    held = 1'b0;
    prev_act = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      rst       = ($urandom_range(0, 1999) == 0);
      #1;
      chk("st_out_valid", out_valid, exp_q.size() > 0);
      chk("st_in_ready", in_ready, exp_q.size() < 2);
      chk("st_count", illegal_count, m_cnt);
      if (exp_q.size() > 0) chk("st_data", act, ref_decode(exp_q[0]));
      if (held) chk("st_hold", act, prev_act);
      acc = in_valid && (exp_q.size() < 2);
      del = (exp_q.size() > 0) && out_ready;
      held = (exp_q.size() > 0) && !out_ready && !flush && !rst;
      prev_act = act;
      tick();
      if (rst) begin
        exp_q.delete();
        m_cnt = 0;
      end else begin
        if (del) begin
          if (ref_decode(exp_q[0]) >> (DW - 1) != 0 && m_cnt < 65535) m_cnt++;
          void'(exp_q.pop_front());
        end
        if (flush) exp_q.delete();
        else if (acc) exp_q.push_back(in_instr);
      end
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
